pipe_work_feeder: RTL and testbench

Work source and result checker for the SHA-256 hashing pipes. Loads one work unit (midstate, 512-bit data template, target, nonce range) and streams one nonce per clock into a pipe. Tracks each nonce through a delay line matched to the pipe latency, compares the returned 32-bit hash word against the target, and queues matching ("golden") nonces in a small FIFO drained by a valid/ready handshake.

---
 rtl/pipe_work_feeder.sv | 141 ++++++++++++++
 tb/tb_pipe_work_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_work_feeder.sv
// Work source and golden-nonce checker for a SHA-256 hashing pipe: streams one
// nonce per clock, matches returned hash words against the target, queues hits.
module pipe_work_feeder #(
  parameter int PIPE_LATENCY = 66,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         abort,
  input  logic [255:0] midstate,
  input  logic [511:0] data_tmpl,
  input  logic [31:0]  target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  output logic [255:0] pipe_state,
  output logic [511:0] pipe_data,
  input  logic [31:0]  pipe_hash,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic [31:0]  golden_nonce,
  output logic         busy,
  output logic         done,
  output logic         overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PIPE_LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic [31:0]   target_reg, nonce_reg, remaining_reg;
  logic [CW-1:0] drain_cnt_reg;
  logic [511:0]  load_data;
  logic          load_ok, run_step, last_issue;

  assign load_ok    = load && !abort && (state_reg == IDLE || state_reg == DONE);
  assign run_step   = (state_reg == RUN) && !abort;
  assign last_issue = (remaining_reg == 32'd1);

  always_comb begin
    load_data          = data_tmpl;
    load_data[127:96]  = nonce_start;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: if (load) state_next = (nonce_count != 32'd0) ? RUN : DONE;
        RUN:        if (last_issue) state_next = DRAIN;
        DRAIN:      if (drain_cnt_reg == CW'(PIPE_LATENCY - 1)) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg == RUN) || (state_reg == DRAIN);
    done = (state_reg == DONE);
  end

  // Pipe outputs only move on a non-empty load or while issuing, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_state    <= '0;
      pipe_data     <= '0;
      target_reg    <= '0;
      nonce_reg     <= '0;
      remaining_reg <= '0;
      drain_cnt_reg <= '0;
    end else begin
      if (load_ok) begin
        target_reg    <= target;
        nonce_reg     <= nonce_start;
        remaining_reg <= nonce_count;
        if (nonce_count != 32'd0) begin
          pipe_state <= midstate;
          pipe_data  <= load_data;
        end
      end else if (run_step) begin
        nonce_reg     <= nonce_reg + 32'd1;
        remaining_reg <= remaining_reg - 32'd1;
        if (!last_issue) pipe_data[127:96] <= nonce_reg + 32'd1;
      end
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + CW'(1) : '0;
    end
  end

  // Delay line tracks which nonce the pipe is returning this cycle.
  logic [PIPE_LATENCY-1:0] dl_valid;
  logic [31:0]             dl_nonce [PIPE_LATENCY];

  always_ff @(posedge clk) begin
    if (reset || abort) dl_valid <= '0;
    else                dl_valid <= {dl_valid[PIPE_LATENCY-2:0], state_reg == RUN};
  end

  always_ff @(posedge clk) begin
    dl_nonce[0] <= nonce_reg;
    for (int i = 1; i < PIPE_LATENCY; i++) dl_nonce[i] <= dl_nonce[i-1];
  end

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_empty, fifo_full, match, pop, push;

  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                        (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign match        = dl_valid[PIPE_LATENCY-1] && (pipe_hash <= target_reg);
  assign pop          = !fifo_empty && golden_ready;
  assign push         = match && (!fifo_full || pop);
  assign golden_valid = !fifo_empty;
  assign golden_nonce = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= dl_nonce[PIPE_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (match && !push) overflow <= 1'b1;
      else if (load_ok)   overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_work_feeder.sv
// Randomized bench for pipe_work_feeder: a delay-line pipe model feeds hashes back,
// and a queue-based scoreboard predicts golden pops, busy/done and overflow.
module tb_pipe_work_feeder;
  localparam int L     = 66;
  localparam int DEPTH = 4;
  localparam int MAXC  = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, load, abort, golden_ready, golden_valid, busy, done, overflow;
  logic [255:0] midstate, pipe_state;
  logic [511:0] data_tmpl, pipe_data;
  logic [31:0]  target, nonce_start, nonce_count, pipe_hash, golden_nonce;

  pipe_work_feeder #(.PIPE_LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load(load), .abort(abort),
    .midstate(midstate), .data_tmpl(data_tmpl), .target(target),
    .nonce_start(nonce_start), .nonce_count(nonce_count),
    .pipe_state(pipe_state), .pipe_data(pipe_data), .pipe_hash(pipe_hash),
    .golden_valid(golden_valid), .golden_ready(golden_ready), .golden_nonce(golden_nonce),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // pipe environment: hash of the nonce seen on pipe_data, returned L cycles later
  logic [31:0] hhist [MAXC];
  logic [31:0] hkey;
  bit          hmul;
  int          rmode;

  // scoreboard
  bit           sched_v [MAXC];
  logic [31:0]  sched_n [MAXC];
  logic [31:0]  exp_q [$];
  bit           exp_ovf;
  int           busy_lo, busy_hi, done_from, run_lo, run_hi;
  logic [31:0]  u_start;
  logic [255:0] exp_state;
  logic [511:0] exp_data;

  function automatic logic [31:0] hash_of(input logic [31:0] n);
    return (hmul ? n * 32'h9E3779B1 : n) ^ hkey;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int c = cyc + 1; c < MAXC; c++) sched_v[c] = 1'b0;
    busy_lo = 0; busy_hi = -1; done_from = -1; run_lo = 0; run_hi = -1;
    exp_state = '0; exp_data = '0; u_start = '0;
  endtask

  task automatic randomize_inputs();
    for (int w = 0; w < 8; w++)  midstate[w*32 +: 32]  = $urandom;
    for (int w = 0; w < 16; w++) data_tmpl[w*32 +: 32] = $urandom;
    target = $urandom; nonce_start = $urandom; nonce_count = $urandom;
  endtask

  task automatic cycle_step();
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "cycle budget exhausted");
    end
    if (!load) randomize_inputs();
    golden_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    pipe_hash    = (cyc >= L) ? hhist[cyc-L] : $urandom;
    @(negedge clk);
    check("busy", 512'(busy), 512'(cyc >= busy_lo && cyc <= busy_hi));
    check("done", 512'(done), 512'(done_from >= 0 && cyc >= done_from));
    check("golden_valid", 512'(golden_valid), 512'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("golden_nonce", 512'(golden_nonce), 512'(exp_q[0]));
    check("overflow", 512'(overflow), 512'(exp_ovf));
    if (cyc >= run_lo && cyc <= run_hi) exp_data[127:96] = u_start + 32'(cyc - run_lo);
    check("pipe_data", pipe_data, exp_data);
    check("pipe_state", 512'(pipe_state), 512'(exp_state));
    hhist[cyc] = hash_of(pipe_data[127:96]);
    if (reset) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0 && golden_ready) begin
        $display("pop   cyc=%0d nonce=%08h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (sched_v[cyc]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(sched_n[cyc]);
        else exp_ovf = 1'b1;
      end
      if (abort) begin
        for (int c = cyc + 1; c < MAXC; c++) sched_v[c] = 1'b0;
        if (busy_hi > cyc) busy_hi = cyc;
        if (run_hi > cyc) run_hi = cyc;
        done_from = -1;
        $display("abort cyc=%0d", cyc);
      end else if (load && !(cyc >= busy_lo && cyc <= busy_hi)) begin
        exp_ovf = 1'b0;
        $display("load  cyc=%0d start=%08h count=%0d target=%08h", cyc, nonce_start, nonce_count, target);
        if (nonce_count == 32'd0) begin
          busy_lo = 0; busy_hi = -1; done_from = cyc + 1;
        end else begin
          busy_lo = cyc + 1; busy_hi = cyc + int'(nonce_count) + L; done_from = busy_hi + 1;
          run_lo = cyc + 1; run_hi = cyc + int'(nonce_count);
          u_start = nonce_start; exp_state = midstate; exp_data = data_tmpl;
          for (int k = 0; k < int'(nonce_count); k++) begin
            if (hash_of(nonce_start + 32'(k)) <= target) begin
              sched_v[cyc+1+k+L] = 1'b1;
              sched_n[cyc+1+k+L] = nonce_start + 32'(k);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_unit(input logic [31:0] s, input logic [31:0] n, input logic [31:0] t);
    randomize_inputs();
    nonce_start = s; nonce_count = n; target = t;
    load = 1'b1;
    cycle_step();
    load = 1'b0;
    repeat (int'(n) + L + 3) cycle_step();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; abort = 1'b0; golden_ready = 1'b0; pipe_hash = '0;
    midstate = '0; data_tmpl = '0; target = '0; nonce_start = '0; nonce_count = '0;
    hkey = '0; hmul = 1'b0; rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_pipe_data", pipe_data, 512'd0);
    check("rst_golden_nonce", 512'(golden_nonce), 512'd0);

    // sweep: every nonce matches, consumer always ready
    run_unit(32'h10, 32'd8, 32'hFFFF_FFFF);

    // selective match: hash = nonce ^ 5 against target 0x12
    hkey = 32'h5; rmode = 2;
    run_unit(32'h0, 32'd40, 32'h12);
    rmode = 0; repeat (8) cycle_step();

    // wrap through 0xFFFFFFFF
    hmul = 1'b1; hkey = $urandom;
    run_unit(32'hFFFF_FFFE, 32'd4, $urandom);

    // overflow with a stalled consumer, then a clean run with pops every cycle
    hmul = 1'b0; hkey = '0; rmode = 1;
    run_unit(32'h100, 32'd6, 32'hFFFF_FFFF);
    check("ovf_set", 512'(overflow), 512'd1);
    rmode = 0; repeat (6) cycle_step();
    run_unit(32'h200, 32'd6, 32'hFFFF_FFFF);
    check("ovf_clear", 512'(overflow), 512'd0);

    // random work units
    for (int u = 0; u < 6; u++) begin
      hmul = 1'b1; hkey = $urandom; rmode = 2;
      run_unit($urandom, 32'($urandom_range(1, 30)), $urandom);
      rmode = 0; repeat (6) cycle_step();
    end

    // abort 10 cycles into a 100-nonce run; a mid-run load must be ignored
    hmul = 1'b0; hkey = '0; rmode = 0;
    randomize_inputs();
    nonce_start = $urandom; nonce_count = 32'd100; target = 32'hFFFF_FFFF;
    load = 1'b1; cycle_step(); load = 1'b0;
    repeat (4) cycle_step();
    load = 1'b1; cycle_step(); load = 1'b0;
    repeat (4) cycle_step();
    abort = 1'b1; load = 1'b1; cycle_step();
    abort = 1'b0; load = 1'b0;
    check("abort_idle_busy", 512'(busy), 512'd0);
    repeat (L + 10) cycle_step();

    // zero-count load goes straight to DONE with no pipe traffic
    randomize_inputs();
    nonce_count = 32'd0;
    load = 1'b1; cycle_step(); load = 1'b0;
    check("count0_done", 512'(done), 512'd1);
    repeat (3) cycle_step();

    // reset mid-run with two entries queued
    rmode = 1;
    run_unit(32'h300, 32'd0, 32'h0);
    randomize_inputs();
    nonce_start = 32'h400; nonce_count = 32'd20; target = 32'hFFFF_FFFF;
    load = 1'b1; cycle_step(); load = 1'b0;
    repeat (L + 2) cycle_step();
    check("pre_reset_valid", 512'(golden_valid), 512'd1);
    reset = 1'b1; cycle_step(); reset = 1'b0;
    check("post_reset_valid", 512'(golden_valid), 512'd0);
    check("post_reset_busy", 512'(busy), 512'd0);
    check("post_reset_state", 512'(pipe_state), 512'd0);
    rmode = 0;
    repeat (L + 5) cycle_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
